load_align_unit: RTL

Parametrised load data path between the execute-stage load request and the SRAM-like data bus. It accepts one load at a time and issues one or two aligned full-width bus reads: two when a misaligned access crosses a word boundary. It merges the returned words, extracts the addressed bytes and sign- or zero-extends them. It also raises an alignment exception when misalignment is disabled, and supports pipeline flush with drain of an in-flight bus read.

---
 rtl/load_align_unit_pkg.sv | 32 +++
 rtl/load_align_unit_lane_extend.sv | 42 ++++
 rtl/load_align_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_pkg.sv
// Shared types for the load alignment data path: access sizes, FSM states, latched request.
package load_align_unit_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5,
    ST_DRAIN = 3'd6
  } ld_state_t;

  typedef struct packed {
    logic [31:0] addr;
    ld_size_e    size;
    logic        unsign;
  } ld_req_t;

  // Low-address-bit mask that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input ld_size_e size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

endpackage

// File: rtl/load_align_unit_lane_extend.sv
// Byte lane extraction and sign/zero extension of a merged two-word read.
// Combinational, no latency; no flow control.
module load_lane_extend
  import load_align_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          merged,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  ld_size_e                   size,
  input  logic                       unsign,
  output logic [XLEN-1:0]            result
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign_bit;

  always_comb begin
    shifted  = XLEN'(merged >> {off, 3'b000});
    keep     = '1;
    sign_bit = shifted[XLEN-1];
    case (size)
      LD_B: begin
        keep     = XLEN'(8'hFF);
        sign_bit = shifted[7];
      end
      LD_H: begin
        keep     = XLEN'(16'hFFFF);
        sign_bit = shifted[15];
      end
      LD_W: begin
        keep     = XLEN'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: ;
    endcase
    // A full-width access keeps every bit, so the fill term vanishes.
    result = (shifted & keep) | (~keep & {XLEN{sign_bit & ~unsign}});
  end

endmodule

// File: rtl/load_align_unit.sv
// Load request to bus read sequencer: 1-2 aligned reads, merge, extract, extend; ALE on illegal access.
// Aligned zero-wait load responds 3 cycles after accept, error 1 cycle; result held until rsp_ready.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [31:0]     ld_addr,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsign,
  output logic            data_req,
  output logic [31:0]     data_addr,
  input  logic            data_addr_ok,
  input  logic            data_data_ok,
  input  logic [XLEN-1:0] data_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_ale
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  ld_state_t       state_q, state_d;
  ld_req_t         req_q, req_d;
  logic            split_q, split_d;
  logic [XLEN-1:0] buf0_q, buf0_d;
  logic [XLEN-1:0] buf1_q, buf1_d;
  logic            data_req_q, data_req_d;
  logic [31:0]     data_addr_q, data_addr_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_ale_q, rsp_ale_d;

  ld_size_e          in_size;
  logic              accept;
  logic              in_ale;
  logic              in_split;
  logic [4:0]        in_end;
  logic [31:0]       base_addr;
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   ext_result;
  logic              entering_resp;

  assign in_size = ld_size_e'(ld_size);
  assign accept  = (state_q == ST_IDLE) && ld_valid && !flush;

  always_comb begin
    in_end   = 5'(ld_addr[OFFW-1:0]) + (5'd1 << ld_size);
    in_split = in_end > 5'(NB);
    in_ale   = ((in_size == LD_D) && (XLEN == 32)) ||
               (!ALLOW_MISALIGN && (|(ld_addr[2:0] & size_mask(in_size))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      split_q     <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      data_req_q  <= 1'b0;
      data_addr_q <= '0;
      rsp_data_q  <= '0;
      rsp_ale_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      split_q     <= split_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      data_req_q  <= data_req_d;
      data_addr_q <= data_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ale_q   <= rsp_ale_d;
    end
  end

  // Next state; flush outranks every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = in_ale ? ST_RESP : ST_REQ0;
      ST_REQ0: begin
        if (flush)             state_d = data_addr_ok ? ST_DRAIN : ST_IDLE;
        else if (data_addr_ok) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (data_data_ok)      state_d = flush ? ST_IDLE : (split_q ? ST_REQ1 : ST_RESP);
        else if (flush)        state_d = ST_DRAIN;
      end
      ST_REQ1: begin
        if (flush)             state_d = data_addr_ok ? ST_DRAIN : ST_IDLE;
        else if (data_addr_ok) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (data_data_ok)      state_d = flush ? ST_IDLE : ST_RESP;
        else if (flush)        state_d = ST_DRAIN;
      end
      ST_RESP:  if (flush || rsp_ready) state_d = ST_IDLE;
      ST_DRAIN: if (data_data_ok)       state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    split_d = split_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (accept) begin
      req_d   = '{addr: ld_addr, size: in_size, unsign: ld_unsign};
      split_d = in_split;
      buf0_d  = '0;
      buf1_d  = '0;
    end
    if ((state_q == ST_WAIT0) && data_data_ok) buf0_d = data_rdata;
    if ((state_q == ST_WAIT1) && data_data_ok) buf1_d = data_rdata;
    merged    = {(split_d ? buf1_d : {XLEN{1'b0}}), buf0_d};
    base_addr = {req_d.addr[31:OFFW], {OFFW{1'b0}}};
  end

  load_lane_extend #(
    .XLEN(XLEN)
  ) u_extend (
    .merged (merged),
    .off    (req_d.addr[OFFW-1:0]),
    .size   (req_d.size),
    .unsign (req_d.unsign),
    .result (ext_result)
  );

  // Result is captured on the transition into RESP so it stays frozen while stalled.
  always_comb begin
    data_req_d    = (state_d == ST_REQ0) || (state_d == ST_REQ1);
    data_addr_d   = data_addr_q;
    if (state_d == ST_REQ0) data_addr_d = base_addr;
    if (state_d == ST_REQ1) data_addr_d = base_addr + 32'(NB);
    entering_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    rsp_ale_d     = rsp_ale_q;
    rsp_data_d    = rsp_data_q;
    if (entering_resp) begin
      rsp_ale_d  = (state_q == ST_IDLE);
      rsp_data_d = (state_q == ST_IDLE) ? '0 : ext_result;
    end
  end

  assign ld_ready  = (state_q == ST_IDLE);
  assign data_req  = data_req_q;
  assign data_addr = data_addr_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_ale   = rsp_ale_q;

endmodule
